// File: rtl/riscv_fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package riscv_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic int unsigned fq_ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Flushable synchronous FIFO of fetch entries; head is read straight out of storage registers.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int unsigned PTR_W = fq_ptr_width(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           push,
    input  entry_t         push_entry,
    input  logic           pop,
    output entry_t         head,
    output logic           valid,
    output logic [PTR_W:0] count
);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign valid = (count_q != '0);
    assign count = count_q;

endmodule

// File: rtl/fetch_frontend.sv
// Instruction-fetch front end: PC, credit-based issue to a 1-cycle synchronous memory,
// redirect with kill of the outstanding read, and a fetch queue toward decode.
module fetch_frontend
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH          = 32,
    parameter int unsigned           INST_MEM_ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] RESET_PC            = '0,
    parameter int unsigned           FQ_DEPTH            = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    output logic [INST_MEM_ADDR_WIDTH-1:0] o_addr_inst,
    output logic                           o_req_inst,
    input  logic [DATA_WIDTH-1:0]          i_rdata_inst,
    input  logic                           i_redirect,
    input  logic [DATA_WIDTH-1:0]          i_redirect_pc,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [DATA_WIDTH-1:0]          o_inst,
    output logic [DATA_WIDTH-1:0]          o_pc,
    output logic [DATA_WIDTH-1:0]          o_pc_plus4
);

    localparam int unsigned PTR_W = fq_ptr_width(FQ_DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } entry_t;

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  inflight_q, inflight_d;
    logic                  kill_q, kill_d;

    logic [PTR_W:0] fq_count;
    logic           fq_valid;
    logic           issue;
    logic           push;
    logic           pop;
    entry_t         push_entry;
    entry_t         head;
    logic           unused_redirect_lsb;

    assign unused_redirect_lsb = ^i_redirect_pc[1:0];

    // Credit uses registered occupancy only, so a same-cycle pop never frees a slot early.
    assign issue = !i_rst && !i_redirect &&
                   (({1'b0, fq_count} + (PTR_W + 2)'(inflight_q)) < (PTR_W + 2)'(FQ_DEPTH));

    assign o_req_inst  = issue;
    assign o_addr_inst = pc_q[INST_MEM_ADDR_WIDTH+1:2];

    assign push            = inflight_q && !kill_q && !i_redirect;
    assign push_entry.pc   = req_pc_q;
    assign push_entry.inst = i_rdata_inst;
    assign pop             = fq_valid && i_ready;

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        kill_d     = 1'b0;
        if (i_redirect) begin
            pc_d   = {i_redirect_pc[DATA_WIDTH-1:2], 2'b00};
            kill_d = inflight_q;
        end else if (issue) begin
            pc_d       = pc_q + DATA_WIDTH'(4);
            req_pc_d   = pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (FQ_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (i_clk),
        .rst        (i_rst),
        .flush      (i_redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .valid      (fq_valid),
        .count      (fq_count)
    );

    assign o_valid    = fq_valid;
    assign o_inst     = head.inst;
    assign o_pc       = head.pc;
    assign o_pc_plus4 = head.pc + DATA_WIDTH'(4);

endmodule
